// File: rtl/fetch_unit.sv
// PC generator and instruction prefetch FIFO between instruction memory and decode.
// Redirects flush the FIFO and restart fetch at the word-aligned target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  output logic        o_misaligned
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [63:0]   mem [DEPTH];
  logic          misaligned;

  logic          not_empty;
  logic          deq;
  logic          enq;
  logic [63:0]   head;

  assign not_empty    = (count != '0);
  assign o_inst_valid = not_empty & ~i_redirect_valid;
  assign deq          = o_inst_valid & i_inst_ready;
  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign enq          = ~i_redirect_valid & ((count < FULL_COUNT) | deq);

  assign head         = mem[rd_ptr];
  assign o_inst       = not_empty ? head[31:0]  : '0;
  assign o_inst_pc    = not_empty ? head[63:32] : '0;
  assign o_imem_addr  = fetch_pc;
  assign o_misaligned = misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      misaligned <= 1'b0;
    end else if (i_redirect_valid) begin
      fetch_pc   <= {i_redirect_pc[31:2], 2'b00};
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      misaligned <= (i_redirect_pc[1:0] != 2'b00);
    end else begin
      misaligned <= 1'b0;
      if (enq) begin
        wr_ptr   <= wr_ptr + AW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      mem[wr_ptr] <= {fetch_pc, i_imem_data};
    end
  end

endmodule
